// File: rtl/fip_pkg.sv
// Shared Q16.16 fixed-point constants and types for the arithmetic library
// (adder, multiplier, divider).
package fip_pkg;

   localparam int INT_BITS  = 16;
   localparam int FRAC_BITS = 16;

   localparam logic [31:0] Q_MAX = 32'h7FFFFFFF;
   localparam logic [31:0] Q_MIN = 32'h80000000;

   typedef logic signed [31:0] fip32_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/fip_udiv_core.sv
// Unsigned iterative restoring divider, one quotient bit per cycle.
// Done and the final quotient are presented combinationally during the last iteration.
module fip_udiv_core #(
   parameter int NUM_W = 48,
   parameter int DEN_W = 33
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_start,
   input  logic [NUM_W-1:0] i_num,
   input  logic [DEN_W-1:0] i_den,
   output logic             o_busy,
   output logic             o_done,
   output logic [NUM_W-1:0] o_quo
);

   localparam int CNT_W = $clog2(NUM_W);

   logic [NUM_W-1:0] r_num;
   logic [NUM_W-1:0] r_acc;
   logic [DEN_W-1:0] r_rem;
   logic [DEN_W-1:0] r_den;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;

   logic [DEN_W:0]   w_rem_sh;
   logic [DEN_W:0]   w_rem_nx;
   logic             w_ge;
   logic [NUM_W-1:0] w_acc_nx;

   // Remainder is always below the divisor, so one extra bit covers the shift.
   assign w_rem_sh = {r_rem, r_num[NUM_W-1]};
   assign w_ge     = (w_rem_sh >= {1'b0, r_den});
   assign w_rem_nx = w_ge ? (w_rem_sh - {1'b0, r_den}) : w_rem_sh;
   assign w_acc_nx = {r_acc[NUM_W-2:0], w_ge};

   assign o_busy = r_busy;
   assign o_done = r_busy && (r_cnt == '0);
   assign o_quo  = w_acc_nx;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_num  <= '0;
         r_acc  <= '0;
         r_rem  <= '0;
         r_den  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (i_start) begin
         r_num  <= i_num;
         r_acc  <= '0;
         r_rem  <= '0;
         r_den  <= i_den;
         r_cnt  <= CNT_W'(NUM_W - 1);
         r_busy <= 1'b1;
      end else if (r_busy) begin
         r_num <= {r_num[NUM_W-2:0], 1'b0};
         r_acc <= w_acc_nx;
         r_rem <= w_rem_nx[DEN_W-1:0];
         if (r_cnt == '0) begin
            r_busy <= 1'b0;
         end else begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

endmodule

// File: rtl/fip_32_div.sv
// Sequential signed Q16.16 divider: sign handling, handshakes and saturation
// around the unsigned restoring core.
module fip_32_div
   import fip_pkg::*;
#(
   parameter int INT_BITS  = fip_pkg::INT_BITS,
   parameter int FRAC_BITS = fip_pkg::FRAC_BITS
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [INT_BITS+FRAC_BITS-1:0] x,
   input  logic [INT_BITS+FRAC_BITS-1:0] y,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [INT_BITS+FRAC_BITS-1:0] quot,
   output logic                          overflow,
   output logic                          div_by_zero
);

   localparam int Q_W   = INT_BITS + FRAC_BITS;
   localparam int NUM_W = Q_W + FRAC_BITS;
   localparam int DEN_W = Q_W + 1;

   div_state_t r_state, w_state_nx;

   logic [Q_W-1:0]   r_quot;
   logic             r_ovf;
   logic             r_dbz;
   logic             r_neg;

   logic             w_accept;
   logic             w_y_zero;
   logic             w_start;
   logic [DEN_W-1:0] w_x_abs;
   logic [DEN_W-1:0] w_y_abs;
   logic [NUM_W-1:0] w_num;
   logic             w_core_busy;
   logic             w_core_done;
   logic [NUM_W-1:0] w_core_quo;
   logic [Q_W:0]     w_sat;

   // Returns {overflow, quotient}; truncated magnitude is clamped to the Q range.
   function automatic logic [Q_W:0] f_saturate(input logic i_neg,
                                               input logic [NUM_W-1:0] i_mag);
      logic [Q_W:0] v;
      if (!i_neg) begin
         v = (i_mag > NUM_W'(Q_MAX)) ? {1'b1, Q_MAX} : {1'b0, i_mag[Q_W-1:0]};
      end else if (i_mag > NUM_W'(Q_MIN)) begin
         v = {1'b1, Q_MIN};
      end else begin
         v = {1'b0, Q_W'(0) - i_mag[Q_W-1:0]};
      end
      return v;
   endfunction

   // Operands widened by one bit so that |-2^31| is representable.
   assign w_x_abs  = x[Q_W-1] ? (DEN_W'(0) - {x[Q_W-1], x}) : {1'b0, x};
   assign w_y_abs  = y[Q_W-1] ? (DEN_W'(0) - {y[Q_W-1], y}) : {1'b0, y};
   assign w_num    = {w_x_abs[Q_W-1:0], {FRAC_BITS{1'b0}}};

   assign w_accept = in_valid && (r_state == IDLE);
   assign w_y_zero = (y == '0);
   assign w_start  = w_accept && !w_y_zero;
   assign w_sat    = f_saturate(r_neg, w_core_quo);

   assign in_ready    = (r_state == IDLE);
   assign out_valid   = (r_state == DONE);
   assign quot        = r_quot;
   assign overflow    = r_ovf;
   assign div_by_zero = r_dbz;

   fip_udiv_core #(
      .NUM_W (NUM_W),
      .DEN_W (DEN_W)
   ) u_core (
      .clk     (clk),
      .reset_n (reset_n),
      .i_start (w_start),
      .i_num   (w_num),
      .i_den   (w_y_abs),
      .o_busy  (w_core_busy),
      .o_done  (w_core_done),
      .o_quo   (w_core_quo)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         IDLE: if (in_valid) w_state_nx = w_y_zero ? DONE : CALC;
         CALC: if (w_core_done || !w_core_busy) w_state_nx = DONE;
         DONE: if (out_ready) w_state_nx = IDLE;
         default: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_quot <= '0;
         r_ovf  <= 1'b0;
         r_dbz  <= 1'b0;
         r_neg  <= 1'b0;
      end else if (w_accept) begin
         r_neg <= x[Q_W-1] ^ y[Q_W-1];
         if (w_y_zero) begin
            r_quot <= x[Q_W-1] ? Q_MIN : Q_MAX;
            r_ovf  <= 1'b0;
            r_dbz  <= 1'b1;
         end
      end else if ((r_state == CALC) && w_core_done) begin
         r_quot <= w_sat[Q_W-1:0];
         r_ovf  <= w_sat[Q_W];
         r_dbz  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fip_32_div.sv
// Directed bench for the Q16.16 sequential divider.
module tb_fip_32_div;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] x;
   logic [31:0] y;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] quot;
   logic        overflow;
   logic        div_by_zero;

   int checks = 0;
   int errors = 0;

   logic [31:0] r_q;
   logic        r_o;
   logic        r_z;
   int          lat;

   fip_32_div dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .x           (x),
      .y           (y),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quot        (quot),
      .overflow    (overflow),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Launch one division and wait (bounded) for the result; leaves it un-acknowledged.
   task automatic launch(input logic [31:0] xi, input logic [31:0] yi);
      chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
      x = xi;
      y = yi;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      x = 32'hDEADBEEF;
      y = 32'h00000000;
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      r_q = quot;
      r_o = overflow;
      r_z = div_by_zero;
   endtask

   task automatic ack();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("out_valid_after_ack", {31'd0, out_valid}, 32'd0);
   endtask

   task automatic run(input string tag, input logic [31:0] xi, input logic [31:0] yi,
                      input logic [31:0] eq, input logic eo, input logic ez);
      launch(xi, yi);
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_quot"}, r_q, eq);
      chk({tag, "_ovf"}, {31'd0, r_o}, {31'd0, eo});
      chk({tag, "_dbz"}, {31'd0, r_z}, {31'd0, ez});
      ack();
   endtask

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      x = '0;
      y = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_quot", quot, 32'd0);
      chk("rst_flags", {30'd0, overflow, div_by_zero}, 32'd0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      launch(32'h00010000, 32'h00020000);
      chk("half_latency", lat, 32'd49);
      chk("half_quot", r_q, 32'h00008000);
      chk("half_ovf", {31'd0, r_o}, 32'd0);
      ack();

      run("neg3_2", 32'hFFFD0000, 32'h00020000, 32'hFFFE8000, 1'b0, 1'b0);
      run("third", 32'h00010000, 32'h00030000, 32'h00005555, 1'b0, 1'b0);

      launch(32'hFFFF0000, 32'h00000000);
      chk("dbz_latency", lat, 32'd1);
      chk("dbz_quot", r_q, 32'h80000000);
      chk("dbz_flag", {31'd0, r_z}, 32'd1);
      chk("dbz_ovf", {31'd0, r_o}, 32'd0);
      ack();

      run("dbz_pos", 32'h00010000, 32'h00000000, 32'h7FFFFFFF, 1'b0, 1'b1);
      run("min_div_1", 32'h80000000, 32'h00010000, 32'h80000000, 1'b0, 1'b0);
      run("min_div_m1", 32'h80000000, 32'hFFFF0000, 32'h7FFFFFFF, 1'b1, 1'b0);
      run("big_div_small", 32'h7FFF0000, 32'h00000100, 32'h7FFFFFFF, 1'b1, 1'b0);
      run("neg_to_zero", 32'hFFFFFFFF, 32'h7FFF0000, 32'h00000000, 1'b0, 1'b0);
      run("neg_small", 32'h00010000, 32'hFFFC0000, 32'hFFFFC000, 1'b0, 1'b0);

      // Backpressure: result held, new operands ignored while busy.
      launch(32'h00060000, 32'h00040000);
      chk("bp_quot0", r_q, 32'h00018000);
      x = 32'h00010000;
      y = 32'h00010000;
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (i % 5 == 4) begin
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_quot", quot, 32'h00018000);
         end
      end
      in_valid = 1'b0;
      ack();

      // Reset in the middle of CALC abandons the operation.
      launch(32'h00010000, 32'h00030000);
      ack();
      chk("pre_rst_quot", quot, 32'h00005555);
      x = 32'h00070000;
      y = 32'h00020000;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_quot", quot, 32'd0);
      chk("midrst_flags", {30'd0, overflow, div_by_zero}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (60) @(posedge clk);
      #1;
      chk("midrst_no_result", {31'd0, out_valid}, 32'd0);
      run("after_rst", 32'h00070000, 32'h00020000, 32'h00038000, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
